// File: rtl/quad_pkg.sv
// quad_pkg: shared definitions for the quadrature decoder.
//   - counting-mode encodings (mode input values)
//   - decoder FSM state type
//   - classify_edge(): maps a {A,B} transition and the counting mode to
//     {count_en, up, illegal}
package quad_pkg;

  localparam logic [1:0] MODE_X1 = 2'd0;
  localparam logic [1:0] MODE_X2 = 2'd1;
  localparam logic [1:0] MODE_X4 = 2'd2;  // 2'd3 also behaves as x4

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic count_en;
    logic up;
    logic illegal;
  } edge_t;

  // Positive rotation is {A,B} = 00 -> 10 -> 11 -> 01 -> 00.
  function automatic edge_t classify_edge(input logic [1:0] prev,
                                          input logic [1:0] cur,
                                          input logic [1:0] mode);
    edge_t      r;
    logic [1:0] diff;
    logic       fwd;
    r.count_en = 1'b0;
    r.up       = 1'b0;
    r.illegal  = 1'b0;
    diff       = prev ^ cur;
    case ({prev, cur})
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd = 1'b1;
      default:                                fwd = 1'b0;
    endcase
    case (diff)
      2'b00: r.count_en = 1'b0;
      2'b11: r.illegal  = 1'b1;
      default: begin
        r.up = fwd;
        case (mode)
          // x1 counts only the 00 <-> 10 edge (B low on both sides)
          MODE_X1: r.count_en = diff[1] & ~prev[0] & ~cur[0];
          MODE_X2: r.count_en = diff[1];
          default: r.count_en = 1'b1;
        endcase
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/quad_filter.sv
// quad_filter: two-flop synchroniser plus run-length glitch filter for one
// encoder channel.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   tick         sample enable from the prescaler
//   load         force the filtered level to the synchronised sample (INIT)
//   pin          raw asynchronous encoder pin
//   level_next   filtered level as it will be after this clock edge; the
//                decoder compares this value so outputs land 1 clk after the
//                accepting tick
module quad_filter
  import quad_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic load,
  input  logic pin,
  output logic level_next
);

  localparam int RUN_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             f_q, f_d;
  logic [RUN_W-1:0] run_q, run_d;

  // Next-state logic: synchroniser shift and run-length acceptance.
  always_comb begin
    sync1_d = pin;
    sync2_d = sync1_q;
    f_d     = f_q;
    run_d   = run_q;
    if (tick) begin
      if (load) begin
        f_d   = sync2_q;
        run_d = '0;
      end else if (sync2_q == f_q) begin
        run_d = '0;
      end else if (run_q == RUN_W'(FILTER_LEN - 1)) begin
        // this tick is the FILTER_LEN-th consecutive differing sample
        f_d   = sync2_q;
        run_d = '0;
      end else begin
        run_d = run_q + RUN_W'(1);
      end
    end else begin
      run_d = run_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      f_q     <= 1'b0;
      run_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      f_q     <= f_d;
      run_q   <= run_d;
    end
  end

  assign level_next = f_d;

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: quadrature encoder decoder with sample-rate prescaler,
// per-channel glitch filter, x1/x2/x4 counting, wrapping signed position
// counter and sticky illegal-transition flag.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   canalA, canalB    raw encoder channels
//   mode              0 = x1, 1 = x2, 2/3 = x4
//   clr               clears position and err (wins over a same-cycle count)
//   position          signed count, wraps modulo 2^POS_W
//   step              one-clk pulse per counted edge
//   dir               direction of the last counted edge (1 = positive)
//   err               sticky: both channels changed within one tick
module quad_decoder
  import quad_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int SAMPLE_HZ  = 500,
  parameter int FILTER_LEN = 4,
  parameter int POS_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    canalA,
  input  logic                    canalB,
  input  logic [1:0]              mode,
  input  logic                    clr,
  output logic signed [POS_W-1:0] position,
  output logic                    step,
  output logic                    dir,
  output logic                    err
);

  localparam int DIV   = CLK_HZ / SAMPLE_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       fill_q, fill_d;
  state_e           state_q, state_d;
  logic [1:0]       prev_q, prev_d;
  logic [POS_W-1:0] position_q, position_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;

  logic             tick;
  logic             init_load;
  logic             fa_next, fb_next;
  logic [1:0]       cur;
  edge_t            edge_s;

  assign tick = (div_cnt_q == CNT_W'(DIV - 1));

  // The synchroniser is cleared by reset, so INIT waits until it has been
  // refilled from the pins (2 clk); otherwise a fast tick would load stale
  // zeros and the refill would look like a real transition.
  assign init_load = tick && (state_q == ST_INIT) && (fill_q == 2'd2);

  quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .load       (init_load),
    .pin        (canalA),
    .level_next (fa_next)
  );

  quad_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .load       (init_load),
    .pin        (canalB),
    .level_next (fb_next)
  );

  assign cur    = {fa_next, fb_next};
  assign edge_s = classify_edge(prev_q, cur, mode);

  // Prescaler and synchroniser-fill counter.
  always_comb begin
    if (tick) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + CNT_W'(1);
    end
    if (fill_q != 2'd2) begin
      fill_d = fill_q + 2'd1;
    end else begin
      fill_d = fill_q;
    end
  end

  // FSM, position counter and output next-state logic.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    position_d = position_q;
    step_d     = 1'b0;
    dir_d      = dir_q;
    err_d      = err_q;
    case (state_q)
      ST_INIT: begin
        if (init_load) begin
          state_d = ST_RUN;
          prev_d  = cur;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        if (tick) begin
          prev_d = cur;
          if (edge_s.illegal) begin
            err_d = 1'b1;
          end else if (edge_s.count_en) begin
            step_d = 1'b1;
            dir_d  = edge_s.up;
            if (edge_s.up) begin
              position_d = position_q + POS_W'(1);
            end else begin
              position_d = position_q - POS_W'(1);
            end
          end else begin
            step_d = 1'b0;
          end
        end else begin
          prev_d = prev_q;
        end
      end
      default: state_d = ST_INIT;
    endcase
    if (clr) begin
      position_d = '0;
      err_d      = 1'b0;
      step_d     = 1'b0;
    end else begin
      err_d = err_d;
    end
  end

  // All decoder state, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      fill_q     <= 2'd0;
      state_q    <= ST_INIT;
      prev_q     <= 2'b00;
      position_q <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      fill_q     <= fill_d;
      state_q    <= state_d;
      prev_q     <= prev_d;
      position_q <= position_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
    end
  end

  assign position = position_q;
  assign step     = step_q;
  assign dir      = dir_q;
  assign err      = err_q;

endmodule
